cpu_mem_responder: RTL and testbench

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

---
 rtl/cpu_mem_responder.sv | 82 ++++++++
 tb/tb_cpu_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Host-loaded word memory that holds the CPU in reset until the final load word arrives.
// The CPU then gets one-cycle, read-first access to the same memory.
module cpu_mem_responder #(
  parameter int SIZE = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] addr_toRAM,
  input  logic            wrEn,
  input  logic [31:0]     data_toRAM,
  output logic [31:0]     data_fromRAM,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [SIZE-1:0] ld_addr,
  input  logic [31:0]     ld_data,
  input  logic            ld_last,
  output logic            cpu_hold,
  output logic [15:0]     ld_count,
  output logic [15:0]     wr_count
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t state;
  state_t state_n;

  logic ld_acc;
  logic cpu_wr;

  logic [31:0] mem [2**SIZE];

  assign ld_acc = (state == LOAD) && ld_valid && !rst;
  assign cpu_wr = (state == RUN) && wrEn && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD: if (ld_valid && ld_last) state_n = RUN;
      RUN:  state_n = RUN;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    cpu_hold = 1'b0;
    unique case (state)
      LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      RUN: ;
    endcase
  end

  // Memory has no reset; the load/write qualifiers already exclude rst cycles.
  always_ff @(posedge clk) begin
    if (ld_acc)      mem[ld_addr]    <= ld_data;
    else if (cpu_wr) mem[addr_toRAM] <= data_toRAM;
  end

  always_ff @(posedge clk) begin
    if (rst)                data_fromRAM <= '0;
    else if (state == RUN)  data_fromRAM <= mem[addr_toRAM];
    else                    data_fromRAM <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_count <= '0;
      wr_count <= '0;
    end else begin
      if (ld_acc && ld_count != 16'hFFFF) ld_count <= ld_count + 16'd1;
      if (cpu_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboarded bench for cpu_mem_responder: directed load/run scenarios,
// randomized traffic, and write-counter saturation against a behavioural model.
module tb_cpu_mem_responder;

  localparam int SIZE = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] addr_toRAM;
  logic            wrEn;
  logic [31:0]     data_toRAM;
  logic [31:0]     data_fromRAM;
  logic            ld_valid;
  logic            ld_ready;
  logic [SIZE-1:0] ld_addr;
  logic [31:0]     ld_data;
  logic            ld_last;
  logic            cpu_hold;
  logic [15:0]     ld_count;
  logic [15:0]     wr_count;

  cpu_mem_responder #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .addr_toRAM(addr_toRAM), .wrEn(wrEn), .data_toRAM(data_toRAM),
    .data_fromRAM(data_fromRAM),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last),
    .cpu_hold(cpu_hold), .ld_count(ld_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model: plain arrays and counters.
  logic [31:0] m_mem [int];
  bit          m_loading = 1'b1;
  int          m_ldc = 0;
  int          m_wrc = 0;

  function automatic string kname(int k);
    case (k)
      0: return "data_fromRAM";
      1: return "ld_count";
      2: return "wr_count";
      3: return "cpu_hold";
      default: return "ld_ready";
    endcase
  endfunction

  function automatic logic [31:0] actual(int k);
    case (k)
      0: return data_fromRAM;
      1: return {16'd0, ld_count};
      2: return {16'd0, wr_count};
      3: return {31'd0, cpu_hold};
      default: return {31'd0, ld_ready};
    endcase
  endfunction

  function automatic void push(int due, int k, logic [31:0] v);
    exp_t e;
    e.due = due;
    e.kind = k;
    e.val = v;
    q.push_back(e);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q.size() != 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (e.due < cyc) begin
          errors++;
          $display("FAIL stale_%s cyc=%0d due=%0d", kname(e.kind), cyc, e.due);
        end else if (actual(e.kind) !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h",
                   kname(e.kind), cyc, actual(e.kind), e.val);
        end
      end
    end
  end

  task automatic step(input logic r, input logic lv, input logic [SIZE-1:0] la,
                      input logic [31:0] ld, input logic ll, input logic we,
                      input logic [SIZE-1:0] a, input logic [31:0] d);
    bit          rd_ok;
    logic [31:0] rd;
    @(negedge clk);
    rst = r; ld_valid = lv; ld_addr = la; ld_data = ld; ld_last = ll;
    wrEn = we; addr_toRAM = a; data_toRAM = d;
    rd_ok = 1'b1;
    rd = 32'd0;
    if (!r && !m_loading) begin
      rd_ok = m_mem.exists(int'(a));
      if (rd_ok) rd = m_mem[int'(a)];
    end
    if (r) begin
      m_loading = 1'b1;
      m_ldc = 0;
      m_wrc = 0;
    end else if (m_loading) begin
      if (lv) begin
        m_mem[int'(la)] = ld;
        if (m_ldc < 65535) m_ldc++;
        if (ll) m_loading = 1'b0;
      end
    end else if (we) begin
      m_mem[int'(a)] = d;
      if (m_wrc < 65535) m_wrc++;
    end
    if (rd_ok) push(cyc + 1, 0, rd);
    push(cyc + 1, 1, 32'(m_ldc));
    push(cyc + 1, 2, 32'(m_wrc));
    push(cyc + 1, 3, {31'd0, m_loading});
    push(cyc + 1, 4, {31'd0, m_loading});
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic rd(input logic [SIZE-1:0] a);
    step(0, 0, '0, '0, 0, 0, a, '0);
  endtask

  task automatic wr(input logic [SIZE-1:0] a, input logic [31:0] d);
    step(0, 0, '0, '0, 0, 1, a, d);
  endtask

  task automatic ld(input logic [SIZE-1:0] a, input logic [31:0] d, input logic last);
    step(0, 1, a, d, last, 0, '0, '0);
  endtask

  task automatic do_rst();
    step(1, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
    wrEn = 0; addr_toRAM = '0; data_toRAM = '0;

    do_rst();
    do_rst();
    // ld_last without ld_valid, and a CPU write while loading: both ignored.
    step(0, 0, 14'd9, 32'h0BAD_0BAD, 1, 1, 14'd0, 32'hFFFF_FFFF);
    ld(14'd0, 32'h1000_0001, 0);
    ld(14'd1, 32'h2000_0002, 0);
    ld(14'd2, 32'h3000_0003, 1);
    rd(14'd1);
    rd(14'd0);
    wr(14'd2, 32'hDEAD_BEEF);
    rd(14'd2);
    step(0, 1, 14'd1, 32'h5555_5555, 1, 0, 14'd1, '0);
    rd(14'd1);
    idle();

    // Reset while the CPU writes: the write must be dropped.
    step(1, 0, '0, '0, 0, 1, 14'd0, 32'hFFFF_FFFF);
    idle();
    ld(14'd5, 32'h0000_0055, 1);
    rd(14'd0);
    rd(14'd5);

    // Randomized load then run traffic over a small window of addresses.
    do_rst();
    for (int i = 0; i < 60; i++) begin
      step(0, ($urandom % 4) != 0, 14'($urandom % 32), $urandom,
           ($urandom % 3) == 0 ? 1'b0 : 1'b0, $urandom % 2,
           14'($urandom % 32), $urandom);
    end
    ld(14'($urandom % 32), $urandom, 1);
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 97) == 0, $urandom % 2, 14'($urandom % 32), $urandom,
           $urandom % 2, $urandom % 2, 14'($urandom % 32), $urandom);
      if (m_loading) ld(14'($urandom % 32), $urandom, 1);
    end

    // Write counter saturation.
    do_rst();
    ld(14'd3, 32'h0000_0003, 1);
    for (int i = 0; i < 65537; i++) wr(14'd3, 32'(i));
    wr(14'd4, 32'hCAFE_F00D);
    rd(14'd3);
    rd(14'd4);
    idle();

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_checks left=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
